// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the dual-port memory FIFO: pops words, absorbs the
// one-cycle read latency in a 2-entry skid buffer and presents them on valid/ready.
module fifo_drain_ctrl #(
  parameter int unsigned BW    = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [BW-1:0]    fifo_data_out,
  input  logic             fifo_error,
  output logic             fifo_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    out_data,
  output logic [CNT_W-1:0] read_count,
  output logic             busy,
  output logic             error_output
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0][BW-1:0]   buf_q, buf_d;
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 pop;
  logic                 overflow;
  logic [2:0]           credit_use;

  assign out_valid    = (occ_q != 2'd0);
  assign out_data     = buf_q[head_q];
  assign read_count   = cnt_q;
  assign busy         = (state_q != IDLE);
  assign error_output = err_q;

  assign pop        = out_valid & out_ready;
  // Slots committed after this edge: buffered + arriving - leaving.
  assign credit_use = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign overflow   = inflight_q & (occ_q == 2'd2) & ~pop;

  // Skid buffer, delivered-word counter and sticky error.
  always_comb begin
    buf_d  = buf_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    err_d  = err_q | fifo_error | overflow;
    if (inflight_q && !overflow) begin
      buf_d[tail_q] = fifo_data_out;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
      cnt_d  = cnt_q + CNT_W'(1);
    end
    if (!overflow) begin
      occ_d = credit_use[1:0];
    end
  end

  // Next-state and read request; no read is issued in the cycle enable drops.
  always_comb begin
    state_d = state_q;
    fifo_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = DRAIN;
        end else begin
          fifo_rd = ~fifo_empty & (credit_use < 3'd2);
        end
      end
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if (!inflight_q && (occ_d == 2'd0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // The credit rule makes a capture into a full buffer impossible.
  assert property (@(posedge clk) disable iff (!reset_L) !overflow);

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO with registered empty flag, and a
// scoreboard of words in write order checked at each downstream handshake.
module tb_fifo_drain_ctrl;

  localparam int unsigned BW    = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_L;
  logic             enable;
  logic             fifo_empty = 1'b1;
  logic [BW-1:0]    fifo_data_out = '0;
  logic             fifo_error;
  logic             fifo_rd;
  logic             out_valid;
  logic             out_ready;
  logic [BW-1:0]    out_data;
  logic [CNT_W-1:0] read_count;
  logic             busy;
  logic             error_output;

  logic [BW-1:0]    mem[$];
  logic [BW-1:0]    exp_q[$];
  logic [BW-1:0]    mon_exp;
  int               n_checks = 0;
  int               n_pass   = 0;

  fifo_drain_ctrl #(.BW(BW), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_error    (fifo_error),
    .fifo_rd       (fifo_rd),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .read_count    (read_count),
    .busy          (busy),
    .error_output  (error_output)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle read latency, empty flag registered.
  always @(posedge clk) begin
    if (fifo_rd) begin
      n_checks++;
      if (mem.size() == 0) $display("FAIL rd_on_empty got fifo_rd=1 want no read from empty FIFO");
      else begin
        n_pass++;
        fifo_data_out <= mem.pop_front();
      end
    end
    fifo_empty <= (mem.size() == 0);
  end

  // Scoreboard: every handshake must deliver the oldest outstanding word.
  always @(negedge clk) begin
    if (reset_L && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL out_word got %h want no word pending", out_data);
      else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) $display("FAIL out_word got %h want %h", out_data, mon_exp);
        else n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_words(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      mem.push_back(BW'(start + i));
      exp_q.push_back(BW'(start + i));
    end
  endtask

  task automatic do_reset();
    reset_L    = 1'b0;
    enable     = 1'b0;
    out_ready  = 1'b0;
    fifo_error = 1'b0;
    mem.delete();
    exp_q.delete();
    step();
    step();
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    reset_L    = 1'b0;
    enable     = 1'b1;
    out_ready  = 1'b1;
    fifo_error = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL rst_data got %h want 0", out_data); else n_pass++;
    n_checks++; if (read_count !== '0) $display("FAIL rst_count got %0d want 0", read_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (error_output !== 1'b0) $display("FAIL rst_err got %b want 0", error_output); else n_pass++;
    n_checks++; if (fifo_rd !== 1'b0) $display("FAIL rst_rd got %b want 0", fifo_rd); else n_pass++;
  endtask

  task automatic test_basic();
    int first_rd = -1, last_rd = -1, rd_cnt = 0, first_v = -1, last_v = -1;
    do_reset();
    push_words(3, 1);
    step();
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (fifo_rd) begin
        if (first_rd < 0) first_rd = i;
        last_rd = i;
        rd_cnt++;
      end
      if (out_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (fifo_empty) begin
        n_checks++;
        if (fifo_rd !== 1'b0) $display("FAIL basic_rd_empty got %b want 0", fifo_rd); else n_pass++;
      end
    end
    n_checks++; if (rd_cnt !== 3) $display("FAIL basic_rd_cnt got %0d want 3", rd_cnt); else n_pass++;
    n_checks++; if (last_rd - first_rd !== 2) $display("FAIL basic_rd_span got %0d want 2", last_rd - first_rd); else n_pass++;
    n_checks++; if (first_v - first_rd !== 2) $display("FAIL basic_latency got %0d want 2", first_v - first_rd); else n_pass++;
    n_checks++; if (last_v - first_v !== 2) $display("FAIL basic_out_span got %0d want 2", last_v - first_v); else n_pass++;
    n_checks++; if (read_count !== CNT_W'(3)) $display("FAIL basic_count got %0d want 3", read_count); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL basic_left got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    int rd_cnt = 0;
    logic [BW-1:0] first;
    do_reset();
    push_words(6, 9);
    first = exp_q[0];
    step();
    enable    = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fifo_rd) rd_cnt++;
      if (i >= 4) begin
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== first) $display("FAIL bp_hold_data got %h want %h", out_data, first); else n_pass++;
      end
    end
    n_checks++; if (rd_cnt !== 2) $display("FAIL bp_reads got %0d want 2", rd_cnt); else n_pass++;
    n_checks++; if (mem.size() !== 4) $display("FAIL bp_fifo_left got %0d want 4", mem.size()); else n_pass++;
    n_checks++; if (read_count !== '0) $display("FAIL bp_count got %0d want 0", read_count); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    n_checks++; if (exp_q.size() !== 0) $display("FAIL bp_timeout got %0d pending want 0", exp_q.size()); else n_pass++;
    n_checks++; if (read_count !== CNT_W'(6)) $display("FAIL bp_count_end got %0d want 6", read_count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_valid_end got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_drain();
    do_reset();
    push_words(8, 2);
    step();
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !out_valid; i++) step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL drain_start got %b want 1", out_valid); else n_pass++;
    enable = 1'b0;
    #1;
    n_checks++; if (fifo_rd !== 1'b0) $display("FAIL drain_rd_now got %b want 0", fifo_rd); else n_pass++;
    step();
    n_checks++; if (fifo_rd !== 1'b0) $display("FAIL drain_rd got %b want 0", fifo_rd); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL drain_busy got %b want 1", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL drain_valid got %b want 1", out_valid); else n_pass++;
    step();
    n_checks++; if (busy !== 1'b0) $display("FAIL drain_idle got %b want 0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", out_valid); else n_pass++;
    n_checks++; if (read_count !== CNT_W'(2)) $display("FAIL drain_count got %0d want 2", read_count); else n_pass++;
    n_checks++; if (mem.size() !== 6) $display("FAIL drain_fifo_left got %0d want 6", mem.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (fifo_rd !== 1'b0) $display("FAIL drain_idle_rd got %b want 0", fifo_rd); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int n_left;
    do_reset();
    push_words(10, 3);
    step();
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !out_valid; i++) step();
    step();
    step();
    #1;
    reset_L = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (fifo_rd !== 1'b0) $display("FAIL mid_rd got %b want 0", fifo_rd); else n_pass++;
    n_checks++; if (read_count !== '0) $display("FAIL mid_count got %0d want 0", read_count); else n_pass++;
    exp_q  = mem;
    n_left = mem.size();
    step();
    step();
    reset_L = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    n_checks++; if (exp_q.size() !== 0) $display("FAIL mid_timeout got %0d pending want 0", exp_q.size()); else n_pass++;
    n_checks++; if (read_count !== CNT_W'(n_left)) $display("FAIL mid_count_end got %0d want %0d", read_count, n_left); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    push_words(17, 0);
    step();
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) step();
    n_checks++; if (exp_q.size() !== 0) $display("FAIL wrap_timeout got %0d pending want 0", exp_q.size()); else n_pass++;
    n_checks++; if (read_count !== CNT_W'(1)) $display("FAIL wrap_count got %0d want 1", read_count); else n_pass++;
  endtask

  task automatic test_error();
    do_reset();
    n_checks++; if (error_output !== 1'b0) $display("FAIL err_init got %b want 0", error_output); else n_pass++;
    push_words(5, 7);
    step();
    enable    = 1'b1;
    out_ready = 1'b1;
    step();
    fifo_error = 1'b1;
    step();
    fifo_error = 1'b0;
    n_checks++; if (error_output !== 1'b1) $display("FAIL err_set got %b want 1", error_output); else n_pass++;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      step();
      n_checks++; if (error_output !== 1'b1) $display("FAIL err_sticky got %b want 1", error_output); else n_pass++;
    end
    n_checks++; if (exp_q.size() !== 0) $display("FAIL err_timeout got %0d pending want 0", exp_q.size()); else n_pass++;
    reset_L = 1'b0;
    #1;
    n_checks++; if (error_output !== 1'b0) $display("FAIL err_clear got %b want 0", error_output); else n_pass++;
    step();
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L    = 1'b0;
    enable     = 1'b0;
    out_ready  = 1'b0;
    fifo_error = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_wrap();
    test_error();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
